// File: rtl/demux32_stream.sv
// Streaming 1-to-2 demultiplexer: steers each input word to channel A or B,
// each channel buffered by its own small FIFO with a delivered-word counter.

module demux32_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      occ;
    logic             pop;

    assign valid = (occ != '0);
    // Full comes from registered occupancy so a same-cycle pop never frees space
    assign full  = (occ == OCC_FULL);
    assign pop   = valid & ready;
    assign out   = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr  <= rptr + PTR_ONE;
                count <= count + CNT_ONE;
            end
            if (push && !pop) begin
                occ <= occ + OCC_ONE;
            end else if (pop && !push) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data;
        end
    end
endmodule

module demux32_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_out,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // Ready depends only on select and registered fill state, never on consumers
    assign in_ready = in_sel ? !full_b : !full_a;
    assign push_a   = in_valid & in_ready & !in_sel;
    assign push_b   = in_valid & in_ready & in_sel;

    demux32_stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_a (
        .clk  (clk),
        .reset(reset),
        .push (push_a),
        .data (in_data),
        .ready(a_ready),
        .out  (a_out),
        .valid(a_valid),
        .full (full_a),
        .count(a_count)
    );

    demux32_stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_b (
        .clk  (clk),
        .reset(reset),
        .push (push_b),
        .data (in_data),
        .ready(b_ready),
        .out  (b_out),
        .valid(b_valid),
        .full (full_b),
        .count(b_count)
    );
endmodule

// File: tb/tb_demux32_stream.sv
// Directed and randomised bench for demux32_stream with a per-channel
// queue scoreboard; a CNT_W=4 twin shares the stimulus for counter wrap.

module tb_demux32_stream;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_out;
    logic        a_valid;
    logic        a_ready = 1'b0;
    logic [31:0] b_out;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [15:0] a_count;
    logic [15:0] b_count;

    logic        in_ready4;
    logic [31:0] a_out4;
    logic        a_valid4;
    logic [31:0] b_out4;
    logic        b_valid4;
    logic [3:0]  a_count4;
    logic [3:0]  b_count4;

    int checks = 0;
    int failures = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    demux32_stream dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .a_out(a_out),
        .a_valid(a_valid), .a_ready(a_ready), .b_out(b_out),
        .b_valid(b_valid), .b_ready(b_ready), .a_count(a_count),
        .b_count(b_count)
    );

    demux32_stream #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .a_out(a_out4),
        .a_valid(a_valid4), .a_ready(a_ready), .b_out(b_out4),
        .b_valid(b_valid4), .b_ready(b_ready), .a_count(a_count4),
        .b_count(b_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic tick();
        logic er;
        logic pa;
        logic pb;
        logic pu;
        #1;
        er = in_sel ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
        pa = a_ready && (qa.size() != 0);
        pb = b_ready && (qb.size() != 0);
        pu = in_valid && er;
        if (!reset) begin
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
            chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
            chk("a_out", a_out, (qa.size() != 0) ? qa[0] : 32'h0);
            chk("b_out", b_out, (qb.size() != 0) ? qb[0] : 32'h0);
            chk("a_count", 32'(a_count), 32'(cnt_a[15:0]));
            chk("b_count", 32'(b_count), 32'(cnt_b[15:0]));
            chk("a_count4", 32'(a_count4), 32'(cnt_a[3:0]));
        end
        @(posedge clk);
        if (reset) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (pa) begin
                void'(qa.pop_front());
                cnt_a++;
            end
            if (pb) begin
                void'(qb.pop_front());
                cnt_b++;
            end
            if (pu && !in_sel) qa.push_back(in_data);
            if (pu && in_sel) qb.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int acc;
        int guard;
        logic [31:0] w;
        @(negedge clk);

        // Reset state
        do_reset();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_a_out", a_out, 32'h0);
        chk("rst_b_out", b_out, 32'h0);

        // One word to each channel, consumers ready
        drive(1'b1, 1'b0, 32'h55555555, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b1);
        #1 chk("t2_a_lat", a_out, 32'h55555555);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        #1 chk("t2_b_lat", b_out, 32'hAAAAAAAA);
        tick();
        tick();
        chk("t2_a_cnt", 32'(a_count), 32'h1);
        chk("t2_b_cnt", 32'(b_count), 32'h1);

        // A stalled: two accepted, third held off until space frees
        do_reset();
        drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
        #1 chk("t3_full", 32'(in_ready), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b1);
        #1 chk("t3_head1", a_out, 32'h1);
        tick();
        #1 chk("t3_head2", a_out, 32'h2);
        chk("t3_accept", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("t3_a_cnt", 32'(a_count), 32'h3);

        // A full and stalled while B streams
        do_reset();
        drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
            #1 chk("t4_b_ready", 32'(in_ready), 32'h1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk("t4_b_cnt", 32'(b_count), 32'h4);
        chk("t4_a_held", 32'(qa.size()), 32'h2);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1 chk("t4_a_still_full", 32'(in_ready), 32'h0);

        // 100-word stream, alternating select, random back-pressure
        do_reset();
        acc = 0;
        guard = 0;
        w = $urandom;
        while (acc < 100 && guard < 2000) begin
            drive(1'b1, acc[0], w, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #1;
            if (in_ready) begin
                acc++;
                w = $urandom;
            end
            tick();
            guard++;
        end
        chk("t5_accepted", 32'(acc), 32'd100);
        guard = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        while ((qa.size() != 0 || qb.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        chk("t5_total", 32'(a_count) + 32'(b_count), 32'd100);
        chk("t5_drained", 32'(a_valid) | 32'(b_valid), 32'h0);

        // Reset mid-stream discards buffered words and the pending push
        do_reset();
        drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("t6_a_valid", 32'(a_valid), 32'h0);
        chk("t6_b_valid", 32'(b_valid), 32'h0);
        chk("t6_a_cnt", 32'(a_count), 32'h0);
        tick();

        // Sixteen pops on A wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("t7_wrap4", 32'(a_count4), 32'h0);
        chk("t7_cnt16", 32'(a_count), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux32_stream.md
# demux32_stream

Streaming 1-to-2 demultiplexer: the inverse of the 32-bit 2:1 mux. It accepts one 32-bit word stream with a per-word select bit and steers each word into one of two independently back-pressured output channels, A or B. Each channel has a small FIFO, so a stalled consumer on one side never corrupts or reorders the other. It sits between a single producer and two downstream consumers; per-channel delivered-word counters serve debug and verification.

## Interface
- WIDTH, 32, data width of input and both outputs
- DEPTH, 2, entries per channel FIFO (power of two, ≥2)
- CNT_W, 16, width of per-channel delivery counters
- Clk  input  1  single clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high
- In_data  input  WIDTH  word offered by producer
- In_sel  input  1  0 = route to A, 1 = route to B
- In_valid  input  1  producer offers In_data/In_sel
- In_ready  output  1  selected channel can accept this cycle
- A_out  output  WIDTH  head word of channel A
- A_valid  output  1  channel A FIFO non-empty
- A_ready  input  1  consumer A accepts head word
- B_out  output  WIDTH  head word of channel B
- B_valid  output  1  channel B FIFO non-empty
- B_ready  input  1  consumer B accepts head word
- A_count  output  CNT_W  words delivered on A since reset
- B_count  output  CNT_W  words delivered on B since reset

## Operation
- Per channel: DEPTH-entry circular FIFO, write/read pointers of log2(DEPTH) bits, occupancy register of log2(DEPTH)+1 bits.
- Full_X = (occupancy_X == DEPTH), taken from registered occupancy only; a same-cycle pop does not free space for a same-cycle push.
- In_ready = In_sel ? !Full_B : !Full_A (combinational on In_sel and registered state; no path from A_ready/B_ready).
- Push to X: In_valid & In_ready & (In_sel selects X). Word written at write pointer; pointer increments, wraps DEPTH-1 → 0.
- Pop from X: X_valid & X_ready. Read pointer increments with wrap; X_count increments by 1, wraps 2^CNT_W-1 → 0.
- Simultaneous push and pop on same channel: occupancy unchanged, both pointers advance.
- Push to one channel and pop on the other in the same cycle: independent, both occur.
- X_valid = (occupancy_X != 0). X_out = entry at read pointer when X_valid, else all zeros.
- Word order preserved within each channel; no ordering relation between channels.
- In_data/In_sel ignored when In_valid=0 or In_ready=0; nothing is dropped or duplicated.
- No FSM beyond the FIFO occupancy state; each channel's state is EMPTY (occ=0), PARTIAL, FULL (occ=DEPTH), moved by push/pop only.

## Timing
- Reset (sampled at a rising edge) overrides everything that cycle: occupancies, pointers, counters → 0; storage contents irrelevant. Reset mid-stream discards all buffered words; any handshake in that cycle is void.
- Outputs after reset: A_valid=B_valid=0, A_out=B_out=0, A_count=B_count=0, In_ready=1.
- Latency: word pushed at edge N is visible on X_out with X_valid=1 after edge N (cycle N+1) if the channel was empty.
- Throughput: one word/cycle into a channel whose consumer holds ready=1 (occupancy stays at 1).
- Consumer stalled: channel accepts exactly DEPTH words, then In_ready=0 while In_sel selects it; In_ready stays 1 while In_sel selects the other, non-full channel.
- Counter update visible the cycle after the pop edge.

## Test plan
- Reset release, In_valid=0 → A_valid=B_valid=0, A_out=B_out=0, counts 0, In_ready=1.
- Push 0x55555555 sel=0 then 0xAAAAAAAA sel=1, both ready=1 → A_out=0x55555555 one cycle after first push, B_out=0xAAAAAAAA one cycle after second; A_count=B_count=1.
- A_ready=0, push 0x00000001, 0x00000002, 0x00000003 to A → first two accepted, In_ready=0 on third; raise A_ready → 0x1, 0x2 delivered in order, then third accepted; A_count=3.
- A stalled and full, stream 0xFFFFFFFF×4 to B with B_ready=1 → In_ready=1 for every B word, B_count=4, A occupancy unchanged.
- Continuous 100-word stream alternating sel, random ready → per-channel order matches scoreboard, A_count+B_count=100, no loss.
- Fill A with 2 words, assert Reset for one cycle with In_valid=1 → A_valid=0, counts 0 next cycle, pushed word discarded; counter wrap checked with CNT_W=4 (16 pops → A_count=0).
